wallace_product_accumulator: RTL and testbench

Downstream consumer of the 4-bit Wallace-tree multiplier's 8-bit product.
Accumulates LEN consecutive products into an ACC_W-bit sum, then presents the sum on a valid/ready output port.
Provides the sequential multiply-accumulate back end for small dot-product and filter datapaths built on the combinational multiplier.

---
 rtl/wallace_product_accumulator.sv | 134 +++++++++++++
 tb/tb_wallace_product_accumulator.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wallace_product_accumulator.sv
// wallace_product_accumulator
// Sums LEN consecutive 8-bit multiplier products into an ACC_W-bit result and
// offers it on a valid/ready output port. Build option: WALLACE_ACC_SATURATE_EN
// clamps the running sum at 2^ACC_W-1 instead of wrapping.
//
// Handshake semantics (both ports): a transfer happens on a rising clock edge
// where valid && ready are both high. in_ready depends only on state and clear,
// never on in_valid. Once out_valid rises, out_sum/out_overflow hold stable
// until the transfer (or a clear) takes place.
module wallace_product_accumulator #(
  parameter int ACC_W = 16,
  parameter int LEN   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_product,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_overflow
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic               out_valid_q, out_valid_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_overflow_q, out_overflow_d;

  logic               accept;
  logic [7:0]         prod_gated;
  logic [ACC_W:0]     sum_wide;
  logic               carry;
  logic [ACC_W-1:0]   acc_next;

  assign in_ready     = (state_q == ACCUM) && !clear;
  assign out_valid    = out_valid_q;
  assign out_sum      = out_sum_q;
  assign out_overflow = out_overflow_q;

  // Adder: the product is gated by accept so an idle (possibly X) bus never
  // reaches the accumulator; one extra bit captures the carry out.
  always_comb begin
    accept     = in_valid && in_ready;
    prod_gated = accept ? in_product : 8'h00;
    sum_wide   = {1'b0, acc_q} + (ACC_W + 1)'(prod_gated);
    carry      = sum_wide[ACC_W];
`ifdef WALLACE_ACC_SATURATE_EN
    acc_next   = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    acc_next   = sum_wide[ACC_W-1:0];
`endif
  end

  // Next-state logic; clear overrides both accept and the output handshake.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    count_d        = count_q;
    ovf_d          = ovf_q;
    out_valid_d    = out_valid_q;
    out_sum_d      = out_sum_q;
    out_overflow_d = out_overflow_q;

    if (clear) begin
      state_d     = ACCUM;
      acc_d       = '0;
      count_d     = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (count_q == LAST_CNT) begin
              out_sum_d      = acc_next;
              out_overflow_d = ovf_q | carry;
              out_valid_d    = 1'b1;
              state_d        = HOLD;
              acc_d          = '0;
              count_d        = '0;
              ovf_d          = 1'b0;
            end else begin
              acc_d   = acc_next;
              count_d = count_q + CNT_W'(1);
              ovf_d   = ovf_q | carry;
            end
          end
        end
        HOLD: begin
          if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            state_d     = ACCUM;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ACCUM;
      acc_q          <= '0;
      count_q        <= '0;
      ovf_q          <= 1'b0;
      out_valid_q    <= 1'b0;
      out_sum_q      <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      count_q        <= count_d;
      ovf_q          <= ovf_d;
      out_valid_q    <= out_valid_d;
      out_sum_q      <= out_sum_d;
      out_overflow_q <= out_overflow_d;
    end
  end

endmodule

// File: tb/tb_wallace_product_accumulator.sv
// Bench for wallace_product_accumulator: a 16-bit/LEN=4 instance driven through
// a scoreboard, plus an 8-bit/LEN=2 instance for the overflow corner.
// Honors WALLACE_ACC_SATURATE_EN when computing expected overflow results.
module tb_wallace_product_accumulator;

  logic clk;
  logic rst_n;

  // instance a: ACC_W=16, LEN=4
  logic        a_in_valid, a_in_ready, a_clear, a_out_valid, a_out_ready, a_out_overflow;
  logic [7:0]  a_in_product;
  logic [15:0] a_out_sum;

  // instance b: ACC_W=8, LEN=2
  logic        b_in_valid, b_in_ready, b_clear, b_out_valid, b_out_ready, b_out_overflow;
  logic [7:0]  b_in_product;
  logic [7:0]  b_out_sum;

  int n_checks = 0;
  int n_pass   = 0;
  int n_results = 0;

  logic [16:0] exp_q[$];
  logic [15:0] m_acc;
  logic        m_ovf;
  int          m_cnt;

  wallace_product_accumulator #(.ACC_W(16), .LEN(4)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_product(a_in_product),
    .clear(a_clear),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_overflow(a_out_overflow)
  );

  wallace_product_accumulator #(.ACC_W(8), .LEN(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_product(b_in_product),
    .clear(b_clear),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_overflow(b_out_overflow)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    else
      n_pass++;
  endtask

  task automatic model_reset();
    m_acc = '0;
    m_ovf = 1'b0;
    m_cnt = 0;
  endtask

  // reference accumulation for one accepted product on instance a
  task automatic model_add(input logic [7:0] p);
    logic [16:0] s;
    s = {1'b0, m_acc} + {9'd0, p};
    m_ovf = m_ovf | s[16];
`ifdef WALLACE_ACC_SATURATE_EN
    m_acc = s[16] ? 16'hFFFF : s[15:0];
`else
    m_acc = s[15:0];
`endif
    m_cnt++;
    if (m_cnt == 4) begin
      exp_q.push_back({m_ovf, m_acc});
      model_reset();
    end
  endtask

  // driver: called at posedge+1, returns at posedge+1 after the accept edge
  task automatic send(input logic [7:0] p);
    int guard;
    guard = 0;
    a_in_valid   = 1'b1;
    a_in_product = p;
    forever begin
      @(negedge clk);
      if (a_in_ready) break;
      guard++;
      if (guard > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge clk);
    if (guard <= 50) model_add(p);
    #1;
    a_in_valid   = 1'b0;
    a_in_product = 8'hxx;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // scoreboard monitor: a handshake completes on the next rising edge
  always @(negedge clk) begin
    if (rst_n && a_out_valid && a_out_ready && !a_clear) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("out_sum", {16'd0, a_out_sum}, {16'd0, e[15:0]});
        check("out_overflow", {31'd0, a_out_overflow}, {31'd0, e[16]});
      end
      n_results++;
    end
  end

  // watchdog
  initial begin
    #200000;
    check("watchdog", 32'd0, 32'd1);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int res_before;
    logic [16:0] e;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_product = 8'hxx; a_clear = 1'b0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_product = 8'h00; b_clear = 1'b0; b_out_ready = 1'b1;
    model_reset();
    #12;
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_out_sum", {16'd0, a_out_sum}, 32'd0);
    check("rst_out_overflow", {31'd0, a_out_overflow}, 32'd0);
    check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // overflow corner on the 8-bit LEN=2 instance
    b_in_valid = 1'b1; b_in_product = 8'hFF;
    @(posedge clk); #1;
    b_in_product = 8'h02;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    check("b_ovf_valid", {31'd0, b_out_valid}, 32'd1);
`ifdef WALLACE_ACC_SATURATE_EN
    check("b_ovf_sum", {24'd0, b_out_sum}, 32'h0000_00FF);
`else
    check("b_ovf_sum", {24'd0, b_out_sum}, 32'h0000_0001);
`endif
    check("b_ovf_flag", {31'd0, b_out_overflow}, 32'd1);
    check("b_hold_ready", {31'd0, b_in_ready}, 32'd0);
    @(posedge clk); #1;
    b_in_valid = 1'b1; b_in_product = 8'h01;
    @(posedge clk); #1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    @(negedge clk);
    check("b_next_valid", {31'd0, b_out_valid}, 32'd1);
    check("b_next_sum", {24'd0, b_out_sum}, 32'h0000_0002);
    check("b_next_flag", {31'd0, b_out_overflow}, 32'd0);
    @(posedge clk); #1;

    // back-to-back 0xFF x4, out_ready high: one bubble
    repeat (4) send(8'hFF);
    @(negedge clk);
    check("bb_valid", {31'd0, a_out_valid}, 32'd1);
    check("bb_hold_ready", {31'd0, a_in_ready}, 32'd0);
    @(negedge clk);
    check("bb_valid_drop", {31'd0, a_out_valid}, 32'd0);
    check("bb_ready_back", {31'd0, a_in_ready}, 32'd1);
    @(posedge clk); #1;

    // backpressure: result held for 6 cycles
    a_out_ready = 1'b0;
    repeat (4) send(8'hFF);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", {31'd0, a_out_valid}, 32'd1);
      check("bp_sum", {16'd0, a_out_sum}, 32'h0000_03FC);
      check("bp_ready", {31'd0, a_in_ready}, 32'd0);
    end
    @(posedge clk); #1;
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_valid_last", {31'd0, a_out_valid}, 32'd1);
    @(negedge clk);
    check("bp_release", {31'd0, a_out_valid}, 32'd0);
    @(posedge clk); #1;

    // gapped input 1,2,3,4
    res_before = n_results;
    for (int p = 1; p <= 4; p++) begin
      idle($urandom_range(0, 3));
      send(8'(p));
    end
    idle(3);
    check("gap_one_result", n_results - res_before, 32'd1);

    // clear after two accepts
    send(8'h10);
    send(8'h20);
    a_clear = 1'b1; a_in_valid = 1'b1; a_in_product = 8'h77;
    @(negedge clk);
    check("clear_in_ready", {31'd0, a_in_ready}, 32'd0);
    @(posedge clk); #1;
    a_clear = 1'b0; a_in_valid = 1'b0; a_in_product = 8'hxx;
    model_reset();
    a_out_ready = 1'b0;
    repeat (4) send(8'h01);
    @(negedge clk);
    check("clr_valid", {31'd0, a_out_valid}, 32'd1);
    check("clr_sum_const", {16'd0, a_out_sum}, 32'd4);
    check("clr_q_size", exp_q.size(), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("clr_sum_model", {16'd0, a_out_sum}, {16'd0, e[15:0]});
    end
    // clear in HOLD drops out_valid without a handshake
    @(posedge clk); #1;
    a_clear = 1'b1;
    @(posedge clk); #1;
    a_clear = 1'b0;
    @(negedge clk);
    check("hold_clear_valid", {31'd0, a_out_valid}, 32'd0);
    check("hold_clear_sum", {16'd0, a_out_sum}, 32'd4);
    check("hold_clear_ready", {31'd0, a_in_ready}, 32'd1);
    @(posedge clk); #1;
    a_out_ready = 1'b1;

    // asynchronous reset mid-accumulation
    send(8'h05);
    send(8'h05);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, a_out_valid}, 32'd0);
    check("arst_sum", {16'd0, a_out_sum}, 32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    res_before = n_results;
    repeat (4) send(8'h05);
    idle(2);
    check("arst_result", n_results - res_before, 32'd1);
    check("arst_sum_20", {16'd0, a_out_sum}, 32'd20);

    // random products with random gaps
    for (int i = 0; i < 12; i++) begin
      idle($urandom_range(0, 2));
      send(8'($urandom_range(0, 255)));
    end
    idle(4);
    check("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
